// File: rtl/mgpio_pkg.sv
// Shared types and constants for the GPIO bus front end and its
// per-bank input change detectors.
package mgpio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_DIR  = 2'd1,
        REG_IE   = 2'd2,
        REG_IP   = 2'd3
    } gpio_reg_t;

    // Edges after reset during which detected changes are ignored, so the
    // transition from the synchroniser's reset value is never reported.
    localparam int PRIME_CYCLES = 3;

endpackage

// File: rtl/mgpio_sync_edge.sv
// Per-bank input conditioning: two-flop synchroniser for the raw pads,
// a one-cycle-delayed copy and a change detector that stays quiet until
// the pipeline has been primed with real pad values after reset.
module mgpio_sync_edge
    import mgpio_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_pin,
    output logic [7:0] o_chg
);

    localparam logic [1:0] PRIME_MAX = 2'(PRIME_CYCLES);

    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_prev;
    logic [1:0] r_cnt;
    logic       w_primed;

    // Synchronise the asynchronous pads and keep last cycle's sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 8'h00;
            r_s2   <= 8'h00;
            r_prev <= 8'h00;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Saturating prime counter: counts edges since reset up to PRIME_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
        end else if (!w_primed) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign w_primed = (r_cnt == PRIME_MAX);
    assign o_chg    = (r_s2 ^ r_prev) & {8{w_primed}};

endmodule

// File: rtl/mgpio_ctrl.sv
// Bus front end for NBANKS 8-bit GPIO banks. Each req/ack access runs
// IDLE -> EXEC -> RESP: EXEC decodes the latched address, pulses the bank
// data/dir enables or updates IE/IP, and captures read data; RESP returns
// ack/err/rdata. Pin-change interrupts are collected per bank into IP and
// ORed into a registered irq.
module mgpio_ctrl
    import mgpio_pkg::*;
#(
    parameter  int NBANKS = 4,
    // One spare bank-select bit so unmapped banks are always addressable
    localparam int ADDR_W = $clog2(NBANKS + 1) + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [7:0]            wdata,
    output logic                  ack,
    output logic                  err,
    output logic [7:0]            rdata,
    output logic                  irq,
    output logic [7:0]            bank_wdata,
    output logic [NBANKS-1:0]     bank_data_en,
    output logic [NBANKS-1:0]     bank_dir_en,
    input  logic [8*NBANKS-1:0]   bank_data_out,
    input  logic [8*NBANKS-1:0]   bank_dir_out,
    input  logic [8*NBANKS-1:0]   gpio_in
);

    localparam int             BW   = ADDR_W - 2;
    localparam logic [BW-1:0]  NB_L = BW'(NBANKS);

    ctrl_state_t                r_state;
    ctrl_state_t                w_next;
    logic                       r_we;
    logic [ADDR_W-1:0]          r_addr;
    logic [7:0]                 r_wdata;
    logic                       r_err_q;
    logic [7:0]                 r_rdata_q;
    logic [NBANKS-1:0][7:0]     r_ie;
    logic [NBANKS-1:0][7:0]     r_ip;
    logic                       r_irq;

    logic [BW-1:0]              w_bank;
    gpio_reg_t                  w_reg;
    logic                       w_mapped;
    logic                       w_exec_wr;
    logic [7:0]                 w_rd_mux;
    logic [NBANKS-1:0]          w_ie_wr;
    logic [NBANKS-1:0][7:0]     w_ip_clr;
    logic [NBANKS-1:0][7:0]     w_chg;

    assign w_bank     = r_addr[ADDR_W-1:2];
    assign w_reg      = gpio_reg_t'(r_addr[1:0]);
    assign w_mapped   = (w_bank < NB_L);
    assign w_exec_wr  = (r_state == EXEC) && r_we && w_mapped;
    assign bank_wdata = r_wdata;
    assign irq        = r_irq;

    // One change detector per bank
    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        mgpio_sync_edge u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .i_pin (gpio_in[8*g +: 8]),
            .o_chg (w_chg[g])
        );
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: fixed three-step sequence, no stalls
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs: enable pulses in EXEC, response in RESP, zero otherwise
    always_comb begin
        ack          = 1'b0;
        err          = 1'b0;
        rdata        = 8'h00;
        bank_data_en = '0;
        bank_dir_en  = '0;
        case (r_state)
            EXEC: begin
                if (r_we && w_mapped) begin
                    for (int b = 0; b < NBANKS; b++) begin
                        if (w_bank == BW'(b)) begin
                            bank_data_en[b] = (w_reg == REG_DATA);
                            bank_dir_en[b]  = (w_reg == REG_DIR);
                        end
                    end
                end
            end
            RESP: begin
                ack   = 1'b1;
                err   = r_err_q;
                rdata = r_rdata_q;
            end
            default: ;
        endcase
    end

    // Latch the access when a request is accepted in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'h00;
        end else if (r_state == IDLE && req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Readback mux over the addressed bank and register
    always_comb begin
        w_rd_mux = 8'h00;
        for (int b = 0; b < NBANKS; b++) begin
            if (w_bank == BW'(b)) begin
                case (w_reg)
                    REG_DATA: w_rd_mux = bank_data_out[8*b +: 8];
                    REG_DIR:  w_rd_mux = bank_dir_out[8*b +: 8];
                    REG_IE:   w_rd_mux = r_ie[b];
                    REG_IP:   w_rd_mux = r_ip[b];
                    default:  w_rd_mux = 8'h00;
                endcase
            end
        end
    end

    // Per-bank IE write strobes and IP write-one-to-clear masks
    always_comb begin
        w_ie_wr  = '0;
        w_ip_clr = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (w_exec_wr && (w_bank == BW'(b))) begin
                w_ie_wr[b]  = (w_reg == REG_IE);
                w_ip_clr[b] = (w_reg == REG_IP) ? r_wdata : 8'h00;
            end
        end
    end

    // Capture error flag and read data in EXEC for the RESP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_q   <= 1'b0;
            r_rdata_q <= 8'h00;
        end else if (r_state == EXEC) begin
            r_err_q   <= ~w_mapped;
            r_rdata_q <= (w_mapped && !r_we) ? w_rd_mux : 8'h00;
        end
    end

    // Interrupt enable/pending: new input-pin changes win over a W1C clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie <= '0;
            r_ip <= '0;
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (w_ie_wr[b]) begin
                    r_ie[b] <= r_wdata;
                end
                r_ip[b] <= (r_ip[b] & ~w_ip_clr[b]) |
                           (w_chg[b] & r_ie[b] & ~bank_dir_out[8*b +: 8]);
            end
        end
    end

    // Registered interrupt line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_ip;
        end
    end

endmodule
